exe_mem_skid_reg: RTL

Parametrised successor to the EX→MEM pipeline register. Carries one EX-stage result per beat into MEM over a valid/ready handshake, with a 2-entry skid buffer so the upstream-facing `in_ready` is a flop. Adds flush for branch-taken squashing. Enables are gated so a bubble can never write memory or the register file.

---
 rtl/exe_mem_pkg.sv | 27 ++
 rtl/pipe_skid_ctrl.sv | 86 ++++++++
 rtl/exe_mem_skid_reg.sv | 92 +++++++++
 3 files changed

// File: rtl/exe_mem_pkg.sv
// exe_mem_pkg: shared types and defaults for the EX->MEM skid register.
//   XLEN_DEF / REG_AW_DEF : default widths of the data fields and register index.
//   exe_mem_payload_t     : payload layout at the default widths. The top declares
//                           the same field order at its own parameter widths.
//   skid_state_e          : occupancy state of a 2-entry skid stage.
package exe_mem_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0]   pc;
    logic [XLEN_DEF-1:0]   alu_res;
    logic [XLEN_DEF-1:0]   val_rm;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [REG_AW_DEF-1:0] dest;
  } exe_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// pipe_skid_ctrl: payload-agnostic control for a 2-entry skid stage.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : squash all held entries next cycle
//   in_valid        : upstream presents a beat
//   in_ready        : registered accept flag
//   out_valid       : main slot holds a beat
//   out_ready       : downstream consumes the beat
//   occupancy       : held entries, 0..2
//   load_main       : write input into the main slot this edge
//   load_skid       : write input into the skid slot this edge
//   shift_skid      : move the skid slot into the main slot this edge
module pipe_skid_ctrl
  import exe_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] occupancy,
  output logic       load_main,
  output logic       load_skid,
  output logic       shift_skid
);

  skid_state_e state_q, state_d;
  logic        in_ready_q;
  logic        in_fire, out_fire;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;

  always_comb begin
    state_d    = state_q;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    // Flush wins over any same-cycle accept, so no strobe is raised for it.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            shift_skid = 1'b1;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EX->MEM pipeline register with a 2-entry skid buffer.
//   clk, rst                            : clock, synchronous active-high reset
//   flush                               : squash all held beats (branch taken)
//   in_valid / in_ready                 : EX-side handshake, in_ready registered
//   in_pc, in_alu_res, in_val_rm        : XLEN-wide payload
//   in_wb_en, in_mem_r_en, in_mem_w_en  : control payload
//   in_dest                             : destination register index
//   out_valid / out_ready               : MEM-side handshake
//   out_*                               : payload of the oldest beat; enables gated by out_valid
//   occupancy                           : held beats, 0..2
module exe_mem_skid_reg
  import exe_mem_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_val_rm,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [REG_AW-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_alu_res,
  output logic [XLEN-1:0]   out_val_rm,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [REG_AW-1:0] out_dest,
  output logic [1:0]        occupancy
);

  // Same field order as exe_mem_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   val_rm;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [REG_AW-1:0] dest;
  } payload_t;

  payload_t in_pl, main_q, skid_q;
  logic     load_main, load_skid, shift_skid;

  assign in_pl = '{pc: in_pc, alu_res: in_alu_res, val_rm: in_val_rm,
                   wb_en: in_wb_en, mem_r_en: in_mem_r_en,
                   mem_w_en: in_mem_w_en, dest: in_dest};

  pipe_skid_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .load_main  (load_main),
    .load_skid  (load_skid),
    .shift_skid (shift_skid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)       main_q <= in_pl;
      else if (shift_skid) main_q <= skid_q;
      if (load_skid)       skid_q <= in_pl;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_alu_res  = main_q.alu_res;
  assign out_val_rm   = main_q.val_rm;
  assign out_dest     = main_q.dest;
  assign out_wb_en    = main_q.wb_en    & out_valid;
  assign out_mem_r_en = main_q.mem_r_en & out_valid;
  assign out_mem_w_en = main_q.mem_w_en & out_valid;

endmodule
